// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_HOLD   = 3'd3,
        ST_HALTED = 3'd4
    } fetch_state_e;

    localparam int unsigned INST_W       = 32;
    localparam logic [31:0] PC_INC       = 32'd4;
    // ECALL halts the core when register x17 holds 10
    localparam logic [4:0]  HALT_REG_IDX = 5'd17;
    localparam logic [31:0] HALT_REG_VAL = 32'd10;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: imem handshake, decode handshake, redirect/halt.
// fetch_count is present only when FETCH_STATS_EN is defined.
interface fetch_unit_if #(parameter int XLEN = 32);
    import fetch_unit_pkg::*;

    logic              imem_req;
    logic [XLEN-1:0]   imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [INST_W-1:0] imem_rdata;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst;
    logic [XLEN-1:0]   inst_pc;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic              halt;
    logic              is_halted;
`ifdef FETCH_STATS_EN
    logic [31:0]       fetch_count;
`endif

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc, is_halted,
        input  imem_gnt, imem_rvalid, imem_rdata, inst_ready,
        input  redirect_valid, redirect_pc, halt
`ifdef FETCH_STATS_EN
        , output fetch_count
`endif
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc, is_halted,
        output imem_gnt, imem_rvalid, imem_rdata, inst_ready,
        output redirect_valid, redirect_pc, halt
`ifdef FETCH_STATS_EN
        , input fetch_count
`endif
    );

endinterface

// File: rtl/fetch_unit.sv
// Multi-cycle fetch stage: one outstanding imem request, redirect squash, sticky halt.
// Optional delivered-instruction counter enabled by FETCH_STATS_EN.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic         clk,
    input  logic         reset_n,
    fetch_unit_if.master bus
);

    fetch_state_e      r_state;
    fetch_state_e      w_state_nxt;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   w_pc_nxt;
    logic [XLEN-1:0]   w_redirect_tgt;
    logic [XLEN-1:0]   w_pc_inc;
    logic              r_squash;
    logic              w_squash_nxt;
    logic              w_capture;
    logic [INST_W-1:0] r_inst;
    logic [XLEN-1:0]   r_inst_pc;
    logic              r_imem_req;
    logic              r_inst_valid;
    logic              r_is_halted;

    assign w_redirect_tgt = bus.redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};
    assign w_pc_inc       = r_pc + XLEN'(PC_INC);

    // Next-state, next-PC and squash decode; halt outranks redirect outranks normal flow
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_squash_nxt = r_squash;
        w_capture    = 1'b0;
        if (bus.halt) begin
            w_state_nxt = ST_HALTED;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_REQ;
                    if (bus.redirect_valid) begin
                        w_pc_nxt = w_redirect_tgt;
                    end else begin
                        w_pc_nxt = r_pc;
                    end
                end
                ST_REQ: begin
                    if (bus.redirect_valid) begin
                        w_pc_nxt = w_redirect_tgt;
                    end else begin
                        w_pc_nxt = r_pc;
                    end
                    if (bus.imem_gnt) begin
                        w_state_nxt  = ST_WAIT;
                        w_squash_nxt = bus.redirect_valid;
                    end else begin
                        w_state_nxt  = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (bus.imem_rvalid) begin
                        // A squashed or same-cycle-redirected response never reaches decode
                        if (bus.redirect_valid || r_squash) begin
                            w_state_nxt  = ST_REQ;
                            w_squash_nxt = 1'b0;
                            if (bus.redirect_valid) begin
                                w_pc_nxt = w_redirect_tgt;
                            end else begin
                                w_pc_nxt = r_pc;
                            end
                        end else begin
                            w_state_nxt = ST_HOLD;
                            w_capture   = 1'b1;
                        end
                    end else if (bus.redirect_valid) begin
                        w_pc_nxt     = w_redirect_tgt;
                        w_squash_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    if (bus.redirect_valid) begin
                        w_pc_nxt    = w_redirect_tgt;
                        w_state_nxt = ST_REQ;
                    end else if (bus.inst_ready) begin
                        w_pc_nxt    = w_pc_inc;
                        w_state_nxt = ST_REQ;
                    end else begin
                        w_state_nxt = ST_HOLD;
                    end
                end
                ST_HALTED: begin
                    w_state_nxt = ST_HALTED;
                end
                default: begin
                    w_state_nxt  = ST_IDLE;
                    w_squash_nxt = 1'b0;
                end
            endcase
        end
    end

    // FSM state plus outputs registered from the next state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_pc         <= RESET_PC;
            r_squash     <= 1'b0;
            r_inst       <= {INST_W{1'b0}};
            r_inst_pc    <= {XLEN{1'b0}};
            r_imem_req   <= 1'b0;
            r_inst_valid <= 1'b0;
            r_is_halted  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_squash     <= w_squash_nxt;
            r_imem_req   <= (w_state_nxt == ST_REQ);
            r_inst_valid <= (w_state_nxt == ST_HOLD);
            r_is_halted  <= (w_state_nxt == ST_HALTED);
            if (w_capture) begin
                r_inst    <= bus.imem_rdata;
                r_inst_pc <= r_pc;
            end
        end
    end

    assign bus.imem_req   = r_imem_req;
    assign bus.imem_addr  = r_pc;
    assign bus.inst_valid = r_inst_valid;
    assign bus.inst       = r_inst;
    assign bus.inst_pc    = r_inst_pc;
    assign bus.is_halted  = r_is_halted;

`ifdef FETCH_STATS_EN
    logic        w_accept;
    logic [31:0] r_fetch_count;

    assign w_accept = (r_state == ST_HOLD) && bus.inst_ready &&
                      !bus.redirect_valid && !bus.halt;

    // Delivered-instruction counter, wraps silently
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_count <= 32'd0;
        end else if (w_accept) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign bus.fetch_count = r_fetch_count;
`endif

endmodule
